// File: rtl/elementwise_pkg.sv
// Shared types and size helpers for the streaming elementwise multiplier.
package elementwise_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPUTE = 2'd1,
        DONE    = 2'd2
    } state_t;

    function automatic int unsigned dot_width(input int unsigned n, input int unsigned len);
        return 2 * n + $clog2(len);
    endfunction

    function automatic int unsigned beats(input int unsigned len, input int unsigned lanes);
        return len / lanes;
    endfunction

endpackage

// File: rtl/mul_lane.sv
// One N x N -> 2N multiplier lane with runtime signed/unsigned selection.
module mul_lane #(
    parameter int unsigned N = 8
) (
    input  logic [N-1:0]   i_a,
    input  logic [N-1:0]   i_b,
    input  logic           i_signed,
    output logic [2*N-1:0] o_prod
);

    logic [2*N-1:0] w_a_ext;
    logic [2*N-1:0] w_b_ext;

    assign w_a_ext = {{N{i_signed & i_a[N-1]}}, i_a};
    assign w_b_ext = {{N{i_signed & i_b[N-1]}}, i_b};

    // The low 2N bits of the extended product are exact in both modes.
    assign o_prod = w_a_ext * w_b_ext;

endmodule

// File: rtl/streaming_elementwise_multiplier.sv
// Multi-channel elementwise multiplier with per-channel dot product; LANES
// shared multipliers per channel walk through the vector over BEATS cycles.
module streaming_elementwise_multiplier
    import elementwise_pkg::*;
#(
    parameter int unsigned N     = 8,
    parameter int unsigned LEN   = 8,
    parameter int unsigned CH    = 2,
    parameter int unsigned LANES = 2,
    localparam int unsigned BEATS = beats(LEN, LANES),
    localparam int unsigned DOT_W = dot_width(N, LEN)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_signed,
    input  logic [CH*LEN*N-1:0]   in_a,
    input  logic [CH*LEN*N-1:0]   in_b,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [CH*LEN*2*N-1:0] out_prod,
    output logic [CH*DOT_W-1:0]   out_dot
);

    localparam int unsigned BW = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned NL = CH * LANES;
    localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);
    localparam int unsigned EXT_W = DOT_W - 2 * N;

    if (LEN % LANES != 0) begin : g_len_check
        $error("LEN must be a multiple of LANES");
    end

    state_t                  r_state;
    logic [BW-1:0]           r_beat;
    logic [CH*LEN*N-1:0]     r_a;
    logic [CH*LEN*N-1:0]     r_b;
    logic                    r_signed;
    logic [CH*LEN*2*N-1:0]   r_prod;
    logic [CH*DOT_W-1:0]     r_dot;

    logic [N-1:0]            w_lane_a   [NL];
    logic [N-1:0]            w_lane_b   [NL];
    logic [2*N-1:0]          w_lane_p   [NL];
    logic [DOT_W-1:0]        w_beat_sum [CH];

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign out_prod  = r_prod;
    assign out_dot   = r_dot;

    // Route element k*LANES+l of every channel to lane l during beat k.
    always_comb begin
        w_lane_a = '{default: '0};
        w_lane_b = '{default: '0};
        for (int c = 0; c < int'(CH); c++) begin
            for (int l = 0; l < int'(LANES); l++) begin
                w_lane_a[c*LANES+l] = r_a[(c*LEN + int'(r_beat)*LANES + l)*N +: N];
                w_lane_b[c*LANES+l] = r_b[(c*LEN + int'(r_beat)*LANES + l)*N +: N];
            end
        end
    end

    for (genvar k = 0; k < NL; k++) begin : g_lane
        mul_lane #(
            .N (N)
        ) u_mul_lane (
            .i_a      (w_lane_a[k]),
            .i_b      (w_lane_b[k]),
            .i_signed (r_signed),
            .o_prod   (w_lane_p[k])
        );
    end

    always_comb begin
        w_beat_sum = '{default: '0};
        for (int c = 0; c < int'(CH); c++) begin
            for (int l = 0; l < int'(LANES); l++) begin
                w_beat_sum[c] = w_beat_sum[c]
                    + {{EXT_W{r_signed & w_lane_p[c*LANES+l][2*N-1]}}, w_lane_p[c*LANES+l]};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_beat   <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_signed <= 1'b0;
            r_prod   <= '0;
            r_dot    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a      <= in_a;
                        r_b      <= in_b;
                        r_signed <= in_signed;
                        r_beat   <= '0;
                        r_dot    <= '0;
                        r_state  <= COMPUTE;
                    end
                end
                COMPUTE: begin
                    for (int c = 0; c < int'(CH); c++) begin
                        for (int l = 0; l < int'(LANES); l++) begin
                            r_prod[(c*LEN + int'(r_beat)*LANES + l)*2*N +: 2*N] <=
                                w_lane_p[c*LANES+l];
                        end
                        r_dot[c*DOT_W +: DOT_W] <= r_dot[c*DOT_W +: DOT_W] + w_beat_sum[c];
                    end
                    if (r_beat == LAST_BEAT) begin
                        r_state <= DONE;
                    end else begin
                        r_beat <= r_beat + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_streaming_elementwise_multiplier.sv
// Directed self-checking bench for streaming_elementwise_multiplier (default parameters).
module tb_streaming_elementwise_multiplier;

    localparam int N   = 8;
    localparam int LEN = 8;
    localparam int CH  = 2;
    localparam int DW  = 19;
    localparam int AW  = CH * LEN * N;
    localparam int PW  = CH * LEN * 2 * N;
    localparam int DTW = CH * DW;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           in_valid = 1'b0;
    logic           in_signed = 1'b0;
    logic           out_ready = 1'b0;
    logic [AW-1:0]  in_a = '0;
    logic [AW-1:0]  in_b = '0;
    logic           in_ready;
    logic           out_valid;
    logic [PW-1:0]  out_prod;
    logic [DTW-1:0] out_dot;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    streaming_elementwise_multiplier #(
        .N     (8),
        .LEN   (8),
        .CH    (2),
        .LANES (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_signed (in_signed),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_prod  (out_prod),
        .out_dot   (out_dot)
    );

    function automatic logic [AW-1:0] fill_ops(input logic [N-1:0] v0, input logic [N-1:0] v1);
        logic [AW-1:0] r;
        r = '0;
        for (int i = 0; i < LEN; i++) begin
            r[i*N +: N]       = v0;
            r[(LEN+i)*N +: N] = v1;
        end
        return r;
    endfunction

    function automatic logic [PW-1:0] fill_prod(input logic [15:0] p0, input logic [15:0] p1);
        logic [PW-1:0] r;
        r = '0;
        for (int i = 0; i < LEN; i++) begin
            r[i*16 +: 16]       = p0;
            r[(LEN+i)*16 +: 16] = p1;
        end
        return r;
    endfunction

    function automatic logic [DTW-1:0] pack_dot(input logic [DW-1:0] d0, input logic [DW-1:0] d1);
        return {d1, d0};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one transaction and hold it for exactly one edge once in_ready is seen.
    task automatic accept(input logic [AW-1:0] a, input logic [AW-1:0] b, input logic s);
        int t;
        t = 0;
        while (!in_ready && t < 20) begin
            tick();
            t++;
        end
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL accept_ready: in_ready=%b required 1", in_ready);
        end
        in_a      = a;
        in_b      = b;
        in_signed = s;
        in_valid  = 1'b1;
        tick();
        in_valid  = 1'b0;
    endtask

    task automatic wait_done(output int edges);
        edges = 0;
        while (out_valid !== 1'b1 && edges < 20) begin
            tick();
            edges++;
        end
    endtask

    task automatic drain();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        int e;
        #3;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_prod !== '0 || out_dot !== '0) begin
            n_fail++;
            $display("FAIL reset_initial: valid=%b ready=%b prod=%h dot=%h required 0 1 0 0",
                     out_valid, in_ready, out_prod, out_dot);
        end
        #5 rst_n = 1'b1;
        tick();
        accept(fill_ops(8'hFF, 8'h11), fill_ops(8'hFF, 8'h22), 1'b0);
        wait_done(e);
        n_checks++;
        if (out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_pre_done: out_valid=%b required 1", out_valid);
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || out_prod !== '0 || out_dot !== '0) begin
            n_fail++;
            $display("FAIL reset_midstream: valid=%b prod=%h dot=%h required 0 0 0",
                     out_valid, out_prod, out_dot);
        end
        #4 rst_n = 1'b1;
        tick();
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: ready=%b valid=%b required 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_unsigned();
        logic [AW-1:0] a;
        logic [AW-1:0] b;
        logic [PW-1:0] ep;
        logic [15:0]   p1 [LEN];
        int            e;
        p1 = '{16'd0, 16'd2, 16'd6, 16'd12, 16'd20, 16'd30, 16'd42, 16'd56};
        a  = '0;
        b  = '0;
        ep = '0;
        for (int i = 0; i < LEN; i++) begin
            a[i*N +: N]            = 8'hFF;
            b[i*N +: N]            = 8'hFF;
            a[(LEN+i)*N +: N]      = 8'(i);
            b[(LEN+i)*N +: N]      = 8'(i + 1);
            ep[i*16 +: 16]         = 16'hFE01;
            ep[(LEN+i)*16 +: 16]   = p1[i];
        end
        accept(a, b, 1'b0);
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL unsigned_early_valid: out_valid=%b required 0", out_valid);
        end
        wait_done(e);
        n_checks++;
        if (out_valid !== 1'b1 || e + 1 != 5) begin
            n_fail++;
            $display("FAIL unsigned_latency: valid=%b cycle=%0d required 1 at cycle 5",
                     out_valid, e + 1);
        end
        n_checks++;
        if (out_prod !== ep) begin
            n_fail++;
            $display("FAIL unsigned_prod: got %h required %h", out_prod, ep);
        end
        n_checks++;
        if (out_dot !== pack_dot(19'd520200, 19'd168)) begin
            n_fail++;
            $display("FAIL unsigned_dot: got %h required %h", out_dot,
                     pack_dot(19'd520200, 19'd168));
        end
        drain();
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL unsigned_fire: valid=%b ready=%b required 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_signed();
        int e;
        accept(fill_ops(8'h80, 8'h00), fill_ops(8'h7F, 8'h00), 1'b1);
        in_signed = 1'b0;  // must not affect the transaction already accepted
        wait_done(e);
        n_checks++;
        if (out_valid !== 1'b1 || out_prod !== fill_prod(16'hC080, 16'h0000)) begin
            n_fail++;
            $display("FAIL signed_prod: valid=%b got %h required %h", out_valid, out_prod,
                     fill_prod(16'hC080, 16'h0000));
        end
        n_checks++;
        if (out_dot !== pack_dot(19'h60400, 19'd0)) begin
            n_fail++;
            $display("FAIL signed_dot: got %h required %h", out_dot, pack_dot(19'h60400, 19'd0));
        end
        drain();
        accept(fill_ops(8'h80, 8'h00), fill_ops(8'h7F, 8'h00), 1'b0);
        wait_done(e);
        n_checks++;
        if (out_valid !== 1'b1 || out_prod !== fill_prod(16'h3F80, 16'h0000)) begin
            n_fail++;
            $display("FAIL unsigned_same_prod: valid=%b got %h required %h", out_valid, out_prod,
                     fill_prod(16'h3F80, 16'h0000));
        end
        n_checks++;
        if (out_dot !== pack_dot(19'd130048, 19'd0)) begin
            n_fail++;
            $display("FAIL unsigned_same_dot: got %h required %h", out_dot,
                     pack_dot(19'd130048, 19'd0));
        end
        drain();
    endtask

    task automatic test_backpressure();
        int             e;
        logic [PW-1:0]  ep;
        logic [DTW-1:0] ed;
        ep = fill_prod(16'd15, 16'h01FC);
        ed = pack_dot(19'd120, 19'd4064);
        accept(fill_ops(8'd3, 8'd2), fill_ops(8'd5, 8'hFE), 1'b0);
        wait_done(e);
        out_ready = 1'b0;
        in_a      = fill_ops(8'd1, 8'd1);
        in_b      = fill_ops(8'd1, 8'd1);
        in_signed = 1'b0;
        in_valid  = 1'b1;
        for (int k = 0; k < 10; k++) begin
            n_checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_handshake[%0d]: valid=%b ready=%b required 1 0",
                         k, out_valid, in_ready);
            end
            n_checks++;
            if (out_prod !== ep || out_dot !== ed) begin
                n_fail++;
                $display("FAIL bp_hold[%0d]: prod=%h dot=%h required %h %h",
                         k, out_prod, out_dot, ep, ed);
            end
            tick();
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_dot !== ed) begin
            n_fail++;
            $display("FAIL bp_fire: ready=%b valid=%b dot=%h required 1 0 %h",
                     in_ready, out_valid, out_dot, ed);
        end
        tick();
        in_valid = 1'b0;
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_accept: in_ready=%b required 0", in_ready);
        end
        wait_done(e);
        n_checks++;
        if (out_valid !== 1'b1 || out_prod !== fill_prod(16'd1, 16'd1)
            || out_dot !== pack_dot(19'd8, 19'd8)) begin
            n_fail++;
            $display("FAIL bp_new_result: valid=%b prod=%h dot=%h required 1 %h %h",
                     out_valid, out_prod, out_dot, fill_prod(16'd1, 16'd1),
                     pack_dot(19'd8, 19'd8));
        end
        drain();
    endtask

    task automatic test_reset_mid();
        int   e;
        logic seen_valid;
        accept(fill_ops(8'hFF, 8'hFF), fill_ops(8'hFF, 8'hFF), 1'b0);
        tick();
        tick();
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (out_dot !== '0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_clear: dot=%h valid=%b required 0 0", out_dot, out_valid);
        end
        #2 rst_n = 1'b1;
        seen_valid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (out_valid !== 1'b0) seen_valid = 1'b1;
        end
        n_checks++;
        if (seen_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_no_emit: out_valid seen=%b required 0", seen_valid);
        end
        accept(fill_ops(8'd1, 8'd1), fill_ops(8'd1, 8'd1), 1'b0);
        wait_done(e);
        n_checks++;
        if (out_valid !== 1'b1 || out_dot !== pack_dot(19'd8, 19'd8)
            || out_prod !== fill_prod(16'd1, 16'd1)) begin
            n_fail++;
            $display("FAIL midreset_next: valid=%b dot=%h prod=%h required 1 %h %h",
                     out_valid, out_dot, out_prod, pack_dot(19'd8, 19'd8),
                     fill_prod(16'd1, 16'd1));
        end
        drain();
    endtask

    task automatic test_back_to_back();
        logic [7:0]  ta0 [3];
        logic [7:0]  tb0 [3];
        logic [7:0]  ta1 [3];
        logic [7:0]  tb1 [3];
        logic        ts  [3];
        logic [15:0] ep0 [3];
        logic [15:0] ep1 [3];
        logic [18:0] ed0 [3];
        logic [18:0] ed1 [3];
        int          acc_cyc [3];
        int          n_acc;
        int          n_res;
        int          cyc;
        logic        acc;
        ta0 = '{8'h02, 8'hFF, 8'hFF};
        tb0 = '{8'h03, 8'h02, 8'h02};
        ta1 = '{8'h10, 8'h7F, 8'h80};
        tb1 = '{8'h10, 8'h7F, 8'h80};
        ts  = '{1'b0, 1'b1, 1'b0};
        ep0 = '{16'h0006, 16'hFFFE, 16'h01FE};
        ep1 = '{16'h0100, 16'h3F01, 16'h4000};
        ed0 = '{19'd48, 19'h7FFF0, 19'd4080};
        ed1 = '{19'd2048, 19'd129032, 19'd131072};
        acc_cyc = '{0, 0, 0};
        n_acc = 0;
        n_res = 0;
        cyc   = 0;
        out_ready = 1'b1;
        in_a      = fill_ops(ta0[0], ta1[0]);
        in_b      = fill_ops(tb0[0], tb1[0]);
        in_signed = ts[0];
        in_valid  = 1'b1;
        while (n_res < 3 && cyc < 60) begin
            if (out_valid === 1'b1) begin
                n_checks++;
                if (out_prod !== fill_prod(ep0[n_res], ep1[n_res])
                    || out_dot !== pack_dot(ed0[n_res], ed1[n_res])) begin
                    n_fail++;
                    $display("FAIL b2b_result[%0d]: prod=%h dot=%h required %h %h", n_res,
                             out_prod, out_dot, fill_prod(ep0[n_res], ep1[n_res]),
                             pack_dot(ed0[n_res], ed1[n_res]));
                end
                n_res++;
            end
            acc = in_valid & in_ready;
            tick();
            cyc++;
            if (acc) begin
                acc_cyc[n_acc] = cyc;
                n_acc++;
                if (n_acc < 3) begin
                    in_a      = fill_ops(ta0[n_acc], ta1[n_acc]);
                    in_b      = fill_ops(tb0[n_acc], tb1[n_acc]);
                    in_signed = ts[n_acc];
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        n_checks++;
        if (n_res != 3 || n_acc != 3) begin
            n_fail++;
            $display("FAIL b2b_count: results=%0d accepts=%0d required 3 3", n_res, n_acc);
        end
        n_checks++;
        if (acc_cyc[1] - acc_cyc[0] != 6 || acc_cyc[2] - acc_cyc[1] != 6) begin
            n_fail++;
            $display("FAIL b2b_spacing: gaps=%0d,%0d required 6,6",
                     acc_cyc[1] - acc_cyc[0], acc_cyc[2] - acc_cyc[1]);
        end
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/streaming_elementwise_multiplier.md
# streaming_elementwise_multiplier

Multi-channel elementwise vector multiplier with runtime signed/unsigned mode and a per-channel dot-product output. CH independent operand pairs are processed together, each LEN elements of N bits. Each channel uses LANES shared multiplier lanes, so one transaction takes LEN/LANES compute beats. The block sits between operand staging and the result consumer, with valid/ready handshakes on both sides.

## Interface
Parameters:
- N, default 8: element width in bits.
- LEN, default 8: elements per vector.
- CH, default 2: number of channels (operand pairs a/b).
- LANES, default 2: multipliers per channel. LEN % LANES must be 0, otherwise elaboration fails.
- Derived, not overridable: BEATS = LEN/LANES and DOT_W = 2N + $clog2(LEN).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset. One clock; reset is asynchronous and active-low.
- in_valid  in  1  operand transaction offered.
- in_ready  out  1  block can accept; equals (state == IDLE).
- in_signed  in  1  1 = two's-complement operands, 0 = unsigned. Sampled on acceptance.
- in_a  in  CH*LEN*N  channel c, element i at bits [(c*LEN+i)*N +: N].
- in_b  in  CH*LEN*N  same layout as in_a.
- out_valid  out  1  results valid.
- out_ready  in  1  consumer accepts results.
- out_prod  out  CH*LEN*2N  a*b per element, at bits [(c*LEN+i)*2N +: 2N].
- out_dot  out  CH*DOT_W  sum over i of a*b, per channel, at bits [c*DOT_W +: DOT_W].

## Operation
- The FSM has three states: IDLE, COMPUTE and DONE.
- **IDLE:** on in_valid && in_ready:
  - latch in_a, in_b and in_signed;
  - clear the beat counter and all dot accumulators;
  - go to COMPUTE.
- **COMPUTE, beat k (0..BEATS-1):**
  - for every channel c and lane l, multiply element i = k*LANES + l;
  - write the product into the out_prod slot and add it into the channel accumulator;
  - after beat BEATS-1, go to DONE.
- **DONE:**
  - out_valid = 1; out_prod and out_dot stay stable;
  - on out_ready, go to IDLE.
- **Arithmetic:**
  - Signed mode: operands are sign-extended and the product is a full 2N-bit two's-complement value; the accumulator sign-extends the product to DOT_W.
  - Unsigned mode: zero-extension throughout.
  - DOT_W is exact, so no overflow is possible.
- **Offers while busy:** in_valid outside IDLE is ignored (in_ready = 0). The offer is not queued.
- **Result retention:** out_prod and out_dot keep their values from DONE until the next acceptance. Only out_dot is cleared on acceptance; out_prod slots are overwritten beat by beat.

## Timing
- **Reset (rst_n low):**
  - state = IDLE, out_valid = 0, out_prod = 0, out_dot = 0, beat counter = 0;
  - in_ready reads 1, but no edge captures during reset.
- **Latency:**
  - acceptance edge E0;
  - compute edges E1..E_BEATS;
  - out_valid is high in the cycle after E_BEATS (cycle BEATS+1 relative to acceptance).
- **Throughput:** with out_ready held high, one transaction every BEATS+2 cycles: the accept cycle, BEATS compute cycles and one DONE cycle. The next in_ready is high the cycle after output fire.
- **Simultaneous events:** in DONE, out_ready and in_valid in the same cycle complete the output only. The input is accepted no earlier than the following IDLE cycle.
- **Reset mid-operation:** rst_n asserted in any state aborts immediately. Partial results and the latched operands are discarded, and nothing is emitted.
- **in_signed change:** changing in_signed during COMPUTE has no effect (latched copy only).

## Structure
- **Shared package elementwise_pkg holds:**
  - the FSM state typedef (IDLE/COMPUTE/DONE);
  - a function dot_width(N, LEN) returning DOT_W;
  - a function beats(LEN, LANES).
- **Sub-module mul_lane:** one N×N→2N multiplier with a signed-mode input, purely combinational. It is instantiated CH*LANES times by a generate loop; beat muxing and accumulation stay in the top level.

## Test plan
Defaults N=8, LEN=8, CH=2, LANES=2, BEATS=4, DOT_W=19.

1. **Reset:** assert rst_n low mid-stream -> out_valid=0, out_prod=0, out_dot=0 immediately; in_ready=1 after release.
2. **Unsigned:**
   - Stimulus: ch0 a=b=0xFF for all i; ch1 a=i, b=i+1.
   - Required: ch0 every prod=0xFE01 and dot=520200; ch1 prod=i*(i+1) and dot=168.
   - out_valid first high 5 cycles after the accept edge.
3. **Signed:**
   - Stimulus: in_signed=1, ch0 a=0x80, b=0x7F for all i.
   - Required: each prod=0xC080 (-16256), dot=0x60400 (-130048).
   - Same operands with in_signed=0 -> prod=0x3F80, dot=130048.
4. **Backpressure:**
   - Stimulus: out_ready low for 10 cycles in DONE, with in_valid high and new operands.
   - Required: out_valid, out_prod and out_dot stable; in_ready=0; new operands not taken.
   - Then raise out_ready -> fire, in_ready=1 next cycle, new operands accepted.
5. **Reset mid-COMPUTE:**
   - Stimulus: rst_n pulse at beat 2.
   - Required: no out_valid; the next transaction (a=1, b=1) gives dot=8 per channel, with no residue.
6. **Back-to-back:**
   - Stimulus: in_valid and out_ready tied high, 3 transactions.
   - Required: acceptances exactly 6 cycles apart, each result matching its own operands.
